fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the controller. Owns the program counter and instruction register. On the controller's `LoadIR` it fetches one 8-bit instruction from instruction memory over a valid-handshake port and presents it as `Opcode`. It also applies the controller's `IncPC`/`LoadPC`/`SelPC` commands to the PC, and stops fetching after a HALT instruction.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_unit_pc_reg.sv | 57 +++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared between the fetch stage and the controller.
//   - opcode nibble constants (upper nibble of an instruction)
//   - NOP_INSTR: instruction loaded into the IR when a fetch is abandoned
//   - fetch_state_t: fetch state machine encoding
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [7:0] NOP_INSTR = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // True when the instruction's opcode nibble is HALT.
    function automatic logic is_halt(input logic [7:0] instr);
        return (instr[7:4] == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter register.
//   clk, reset : clock, synchronous active-high reset (PC <= RESET_PC)
//   en_i       : command enable; when low the PC holds regardless of commands
//   load_i     : load command (beats inc_i)
//   sel_i      : load source, 1 = zero-extended imm_i, 0 = low bits of reg_i
//   inc_i      : increment command, wraps modulo 2^PC_WIDTH
//   imm_i      : 4-bit immediate target
//   reg_i      : 8-bit register target
//   pc_o       : current PC
module pc_reg #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic                load_i,
    input  logic                sel_i,
    input  logic                inc_i,
    input  logic [3:0]          imm_i,
    input  logic [7:0]          reg_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    // Next PC: load has priority over increment; nothing changes when disabled.
    always_comb begin
        pc_d = pc_q;
        if (!en_i) begin
            pc_d = pc_q;
        end else if (load_i) begin
            if (sel_i) begin
                pc_d = {{(PC_WIDTH-4){1'b0}}, imm_i};
            end else begin
                pc_d = reg_i[PC_WIDTH-1:0];
            end
        end else if (inc_i) begin
            pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_WIDTH'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the controller.
//   clk, reset             : clock, synchronous active-high reset
//   LoadIR                 : fetch request from the controller
//   IncPC, LoadPC, SelPC   : PC commands (load beats increment)
//   ImmediateData, RegData : PC load targets
//   imem_req, imem_addr    : request/address to instruction memory
//   imem_rdata, imem_valid : instruction memory response
//   Opcode, IRValid        : instruction register and its valid flag
//   PC                     : program counter
//   Halted                 : a HALT was fetched; only reset leaves this state
//   fetch_error            : sticky; timeout or overrun seen
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                LoadIR,
    input  logic                IncPC,
    input  logic                LoadPC,
    input  logic                SelPC,
    input  logic [3:0]          ImmediateData,
    input  logic [7:0]          RegData,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [7:0]          imem_rdata,
    input  logic                imem_valid,
    output logic [7:0]          Opcode,
    output logic [PC_WIDTH-1:0] PC,
    output logic                IRValid,
    output logic                Halted,
    output logic                fetch_error
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    fetch_state_t        state_q;
    logic                req_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic [7:0]          opcode_q;
    logic                irvalid_q;
    logic                halted_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PC_WIDTH-1:0] pc_s;
    logic                pc_en_s;

    // PC commands are frozen once halted.
    assign pc_en_s = (state_q != HALTED);

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .en_i   (pc_en_s),
        .load_i (LoadPC),
        .sel_i  (SelPC),
        .inc_i  (IncPC),
        .imm_i  (ImmediateData),
        .reg_i  (RegData),
        .pc_o   (pc_s)
    );

    // Fetch FSM with IR, address capture, timeout counter and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            opcode_q  <= NOP_INSTR;
            irvalid_q <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Address is the pre-command PC, so a same-cycle IncPC
                    // does not affect this fetch.
                    if (LoadIR) begin
                        addr_q    <= pc_s;
                        req_q     <= 1'b1;
                        irvalid_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // A new request while one is outstanding is dropped.
                    if (LoadIR) begin
                        err_q <= 1'b1;
                    end
                    // Valid data wins over a timeout in the same cycle.
                    if (imem_valid) begin
                        opcode_q  <= imem_rdata;
                        irvalid_q <= 1'b1;
                        req_q     <= 1'b0;
                        if (is_halt(imem_rdata)) begin
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end else if (cnt_q == TIMEOUT[CNT_W-1:0]) begin
                        opcode_q  <= NOP_INSTR;
                        irvalid_q <= 1'b1;
                        err_q     <= 1'b1;
                        req_q     <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign Opcode      = opcode_q;
    assign PC          = pc_s;
    assign IRValid     = irvalid_q;
    assign Halted      = halted_q;
    assign fetch_error = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       LoadIR, IncPC, LoadPC, SelPC;
    logic [3:0] ImmediateData;
    logic [7:0] RegData;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_valid;
    logic [7:0] Opcode;
    logic [7:0] PC;
    logic       IRValid, Halted, fetch_error;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.PC_WIDTH(8), .RESET_PC(0), .TIMEOUT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .LoadIR        (LoadIR),
        .IncPC         (IncPC),
        .LoadPC        (LoadPC),
        .SelPC         (SelPC),
        .ImmediateData (ImmediateData),
        .RegData       (RegData),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .Opcode        (Opcode),
        .PC            (PC),
        .IRValid       (IRValid),
        .Halted        (Halted),
        .fetch_error   (fetch_error)
    );

    always #5 clk = ~clk;

    // ctl = {reset, LoadIR, IncPC, LoadPC, SelPC}; flg = {IRValid, Halted, fetch_error}
    typedef struct {
        string      name;
        logic [4:0] ctl;
        logic [3:0] imm;
        logic [7:0] regd;
        logic       vld;
        logic [7:0] rdata;
        logic       e_req;
        logic [7:0] e_addr;
        logic [7:0] e_op;
        logic [7:0] e_pc;
        logic [2:0] e_flg;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input string n, input logic [4:0] ctl, input logic [3:0] imm,
                                input logic [7:0] regd, input logic vld, input logic [7:0] rdata,
                                input logic e_req, input logic [7:0] e_addr, input logic [7:0] e_op,
                                input logic [7:0] e_pc, input logic [2:0] e_flg);
        vec_t v;
        v.name = n; v.ctl = ctl; v.imm = imm; v.regd = regd; v.vld = vld; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_op = e_op; v.e_pc = e_pc; v.e_flg = e_flg;
        return v;
    endfunction

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [3:0] imm, input logic [7:0] regd,
                         input logic vld, input logic [7:0] rdata);
        {reset, LoadIR, IncPC, LoadPC, SelPC} = ctl;
        ImmediateData = imm;
        RegData       = regd;
        imem_valid    = vld;
        imem_rdata    = rdata;
    endtask

    task automatic check_all(input string n, input logic e_req, input logic [7:0] e_addr,
                             input logic [7:0] e_op, input logic [7:0] e_pc, input logic [2:0] e_flg);
        check({n, ".req"},  {7'b0, imem_req}, {7'b0, e_req});
        check({n, ".addr"}, imem_addr, e_addr);
        check({n, ".op"},   Opcode, e_op);
        check({n, ".pc"},   PC, e_pc);
        check({n, ".flags"}, {5'b0, IRValid, Halted, fetch_error}, {5'b0, e_flg});
    endtask

    initial begin
        //                name          ctl      imm    regd   vld   rdata  req   addr   op     pc     flg
        vecs[0]  = mk("reset",        5'b10000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[1]  = mk("fetch_req",    5'b01000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[2]  = mk("fetch_data",   5'b00000, 4'h0, 8'h00, 1'b1, 8'h4A, 1'b0, 8'h00, 8'h4A, 8'h00, 3'b100);
        vecs[3]  = mk("jmp_imm",      5'b00011, 4'h9, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h4A, 8'h09, 3'b100);
        vecs[4]  = mk("jmp_reg_inc",  5'b00110, 4'h9, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 8'h4A, 8'h3C, 3'b100);
        vecs[5]  = mk("jmp_reg_ff",   5'b00010, 4'h0, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 8'h4A, 8'hFF, 3'b100);
        vecs[6]  = mk("fetch_wrap",   5'b01100, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h4A, 8'h00, 3'b000);
        vecs[7]  = mk("wait_inc",     5'b00100, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h4A, 8'h01, 3'b000);
        vecs[8]  = mk("overrun",      5'b01000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h4A, 8'h01, 3'b001);
        vecs[9]  = mk("overrun_done", 5'b00000, 4'h0, 8'h00, 1'b1, 8'h3B, 1'b0, 8'hFF, 8'h3B, 8'h01, 3'b101);
        vecs[10] = mk("idle_valid",   5'b00000, 4'h0, 8'h00, 1'b1, 8'h77, 1'b0, 8'hFF, 8'h3B, 8'h01, 3'b101);
        vecs[11] = mk("reset2",       5'b10000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[12] = mk("fetch_req2",   5'b01000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[13] = mk("reset_wait",   5'b10000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[14] = mk("late_valid",   5'b00000, 4'h0, 8'h00, 1'b1, 8'h55, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[15] = mk("halt_req",     5'b01100, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h01, 3'b000);
        vecs[16] = mk("halt_data",    5'b00000, 4'h0, 8'h00, 1'b1, 8'hF0, 1'b0, 8'h00, 8'hF0, 8'h01, 3'b110);
        vecs[17] = mk("halt_ldir",    5'b01100, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'hF0, 8'h01, 3'b110);
        vecs[18] = mk("halt_ldpc",    5'b00011, 4'h5, 8'h00, 1'b1, 8'h12, 1'b0, 8'h00, 8'hF0, 8'h01, 3'b110);
        vecs[19] = mk("reset3",       5'b10000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[20] = mk("pre_to_req",   5'b01000, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
        vecs[21] = mk("pre_to_data",  5'b00000, 4'h0, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5, 8'h00, 3'b100);

        drive(5'b10000, 4'h0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].ctl, vecs[i].imm, vecs[i].regd, vecs[i].vld, vecs[i].rdata);
            @(posedge clk);
            #1;
            check_all(vecs[i].name, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_op,
                      vecs[i].e_pc, vecs[i].e_flg);
        end

        // Timeout: request from PC 0x07, memory never answers.
        drive(5'b00010, 4'h0, 8'h07, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        drive(5'b01000, 4'h0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        check_all("to_req", 1'b1, 8'h07, 8'hA5, 8'h07, 3'b000);
        drive(5'b00000, 4'h0, 8'h00, 1'b0, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) begin
                check("to_wait.irv", {7'b0, IRValid}, 8'h00);
                check("to_wait.req", {7'b0, imem_req}, 8'h01);
            end else begin
                check_all("to_fire", 1'b0, 8'h07, 8'h00, 8'h07, 3'b101);
            end
        end

        // After a timeout the unit is back in IDLE and fetches again.
        drive(5'b01000, 4'h0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        drive(5'b00000, 4'h0, 8'h00, 1'b1, 8'h2C);
        @(posedge clk);
        #1;
        check_all("after_to", 1'b0, 8'h07, 8'h2C, 8'h07, 3'b101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
